// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: byte/half/word loads and stores against a synchronous
// data memory, with a one-cycle registered hand-off to write-back.
module mem_access_stage #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DMEM_DEPTH     = 256,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_IE_valid,
  input  logic                      i_ctrl_mem_read,
  input  logic                      i_ctrl_mem_write,
  input  logic [2:0]                i_ctrl_mem_size,
  input  logic                      i_ctrl_reg_write,
  input  logic [DATA_WIDTH-1:0]     i_IE_result,
  input  logic [DATA_WIDTH-1:0]     i_IE_data_write,
  input  logic [REG_ADDR_WIDTH-1:0] i_IE_rd_addr,
  output logic                      o_MEM_valid,
  output logic [DATA_WIDTH-1:0]     o_MEM_result,
  output logic [REG_ADDR_WIDTH-1:0] o_MEM_rd_addr,
  output logic                      o_MEM_reg_write,
  output logic                      o_MEM_fault
);

  localparam int unsigned IdxW = $clog2(DMEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DMEM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [IdxW-1:0]       word_idx;
  logic [1:0]            byte_off;
  logic                  size_bad;
  logic                  fault_d;
  logic                  store_en;
  logic [3:0]            lane_en;
  logic [DATA_WIDTH-1:0] store_data;

  logic                      valid_d, valid_q;
  logic                      reg_write_d, reg_write_q;
  logic                      fault_q;
  logic                      is_load_d, is_load_q;
  logic [2:0]                size_d, size_q;
  logic [1:0]                off_d, off_q;
  logic [DATA_WIDTH-1:0]     alu_d, alu_q;
  logic [REG_ADDR_WIDTH-1:0] rd_d, rd_q;

  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [DATA_WIDTH-1:0] load_data;

  // Upper address bits are dropped, so the memory aliases every 4*DMEM_DEPTH bytes.
  assign word_idx = i_IE_result[IdxW+1:2];
  assign byte_off = i_IE_result[1:0];

  always_comb begin
    size_bad = 1'b0;
    case (i_ctrl_mem_size)
      3'b000, 3'b100: size_bad = 1'b0;
      3'b001, 3'b101: size_bad = byte_off[0];
      3'b010:         size_bad = |byte_off;
      default:        size_bad = 1'b1;
    endcase
    fault_d = i_IE_valid & (i_ctrl_mem_read | i_ctrl_mem_write) &
              (size_bad | (i_ctrl_mem_read & i_ctrl_mem_write));
  end

  always_comb begin
    lane_en    = 4'b1111;
    store_data = i_IE_data_write;
    case (i_ctrl_mem_size[1:0])
      2'b00: begin
        lane_en    = 4'b0001 << byte_off;
        store_data = {4{i_IE_data_write[7:0]}};
      end
      2'b01: begin
        lane_en    = byte_off[1] ? 4'b1100 : 4'b0011;
        store_data = {2{i_IE_data_write[15:0]}};
      end
      default: begin
        lane_en    = 4'b1111;
        store_data = i_IE_data_write;
      end
    endcase
    store_en = i_IE_valid & i_ctrl_mem_write & ~fault_d & ~i_reset;
  end

  // Read-first RAM: the output register samples the old word on a same-edge write.
  always_ff @(posedge i_clk) begin
    if (store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem_q[word_idx][8*i +: 8] <= store_data[8*i +: 8];
      end
    end
    rdata_q <= mem_q[word_idx];
  end

  always_comb begin
    valid_d     = i_IE_valid;
    reg_write_d = i_IE_valid & i_ctrl_reg_write & ~fault_d;
    is_load_d   = i_IE_valid & i_ctrl_mem_read & ~fault_d;
    size_d      = i_ctrl_mem_size;
    off_d       = byte_off;
    alu_d       = i_IE_result;
    rd_d        = i_IE_rd_addr;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      fault_q     <= 1'b0;
      is_load_q   <= 1'b0;
      size_q      <= 3'b000;
      off_q       <= 2'b00;
      alu_q       <= '0;
      rd_q        <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      fault_q     <= fault_d;
      is_load_q   <= is_load_d;
      size_q      <= size_d;
      off_q       <= off_d;
      alu_q       <= alu_d;
      rd_q        <= rd_d;
    end
  end

  always_comb begin
    load_byte = rdata_q[{off_q, 3'b000} +: 8];
    load_half = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (size_q)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_data = {24'h000000, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b101:  load_data = {16'h0000, load_half};
      default: load_data = rdata_q;
    endcase
  end

  assign o_MEM_valid     = valid_q;
  assign o_MEM_result    = is_load_q ? load_data : alu_q;
  assign o_MEM_rd_addr   = rd_q;
  assign o_MEM_reg_write = reg_write_q;
  assign o_MEM_fault     = fault_q;

endmodule
